ddr_avl_responder: RTL and testbench

Avalon-MM burst responder that stands in for the DDR4 EMIF user port (`ddr_avl_*`) during bring-up and simulation of the MobileNet datapath. It accepts 512-bit burst reads and writes from the accelerator's DDR master, stores data in an on-chip RAM, and returns read beats with fixed latency. It also emulates `local_init_done` calibration timing and exposes beat counters to the Nios status registers.

---
 rtl/ddr_avl_responder.sv | 202 ++++++++++++++++++++
 tb/tb_ddr_avl_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_avl_responder.sv
// Avalon-MM burst responder standing in for the DDR4 EMIF user port: on-chip RAM with
// byte-enable writes, fixed-latency burst reads, emulated calibration and beat counters.
module ddr_avl_responder #(
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned ADDR_W      = 26,
    parameter int unsigned BURST_W     = 7,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned RD_LATENCY  = 4,   // legal range 2..15
    parameter int unsigned INIT_CYCLES = 64
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    output logic                ddr_avl_local_init_done,
    output logic                ddr_avl_ready,
    input  logic                ddr_avl_rd_req,
    input  logic                ddr_avl_wr_req,
    input  logic [ADDR_W-1:0]   ddr_avl_address,
    input  logic [BURST_W-1:0]  ddr_avl_bl_size,
    input  logic [DATA_W-1:0]   ddr_avl_write_data,
    input  logic [DATA_W/8-1:0] ddr_avl_be,
    output logic [DATA_W-1:0]   ddr_avl_rd_data,
    output logic                ddr_avl_rd_data_vld,
    output logic [31:0]         wr_beat_num,
    output logic [31:0]         rd_beat_num,
    output logic                proto_err
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << MEM_AW;
    // Stage 0 is the RAM read register; the last stage drives the bus.
    localparam int unsigned PIPE_D = RD_LATENCY - 1;
    localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {StInit, StIdle, StWrBurst, StRdBurst} state_e;

    state_e              state_q;
    logic [INIT_W-1:0]   init_cnt_q;
    logic                init_done_q;
    logic                ready_q;
    logic [MEM_AW-1:0]   idx_q;
    logic [BURST_W-1:0]  len_q;
    logic [BURST_W-1:0]  beat_q;
    logic [BURST_W-1:0]  ret_q;
    logic                pipe_vld_q  [PIPE_D];
    logic [DATA_W-1:0]   pipe_data_q [PIPE_D];
    logic [31:0]         wr_cnt_q;
    logic [31:0]         rd_cnt_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                bl_zero;
    logic [BURST_W-1:0]  cmd_len;
    logic [MEM_AW-1:0]   cmd_idx;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_widx;
    logic                rd_issue;
    logic                out_vld;
    logic                unused_addr;

    assign bl_zero     = (ddr_avl_bl_size == '0);
    assign cmd_len     = bl_zero ? BURST_W'(1) : ddr_avl_bl_size;
    assign cmd_idx     = ddr_avl_address[MEM_AW-1:0];
    assign rd_issue    = (state_q == StRdBurst) && (beat_q < len_q);
    assign out_vld     = pipe_vld_q[PIPE_D-1];
    // Upper address bits alias onto the RAM; wrap is silent.
    assign unused_addr = ^ddr_avl_address[ADDR_W-1:MEM_AW];

    always_comb begin
        mem_we   = 1'b0;
        mem_widx = idx_q;
        if (state_q == StIdle && ddr_avl_wr_req) begin
            mem_we   = 1'b1;
            mem_widx = cmd_idx;
        end else if (state_q == StWrBurst && ddr_avl_wr_req) begin
            mem_we = 1'b1;
        end
    end

    // RAM has no reset: contents survive sys_rst_n.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (ddr_avl_be[k]) begin
                    mem[mem_widx][8*k +: 8] <= ddr_avl_write_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            idx_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            ret_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_q       <= 1'b0;
            for (int s = 0; s < PIPE_D; s++) begin
                pipe_vld_q[s]  <= 1'b0;
                pipe_data_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_issue;
            if (rd_issue) begin
                pipe_data_q[0] <= mem[idx_q];
            end
            // Data stages only load on valid so the bus holds its last beat.
            for (int s = 1; s < PIPE_D; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                if (pipe_vld_q[s-1]) begin
                    pipe_data_q[s] <= pipe_data_q[s-1];
                end
            end

            if (mem_we) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
            if (out_vld) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end

            unique case (state_q)
                StInit: begin
                    if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                        state_q     <= StIdle;
                        init_done_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + INIT_W'(1);
                    end
                end
                StIdle: begin
                    if (ddr_avl_wr_req) begin
                        len_q  <= cmd_len;
                        idx_q  <= cmd_idx + MEM_AW'(1);
                        beat_q <= BURST_W'(1);
                        if (bl_zero || ddr_avl_rd_req) begin
                            err_q <= 1'b1;
                        end
                        if (cmd_len != BURST_W'(1)) begin
                            state_q <= StWrBurst;
                        end
                    end else if (ddr_avl_rd_req) begin
                        len_q   <= cmd_len;
                        idx_q   <= cmd_idx;
                        beat_q  <= '0;
                        ret_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= StRdBurst;
                        if (bl_zero) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StWrBurst: begin
                    if (ddr_avl_rd_req) begin
                        err_q <= 1'b1;
                    end
                    if (ddr_avl_wr_req) begin
                        idx_q  <= idx_q + MEM_AW'(1);
                        beat_q <= beat_q + BURST_W'(1);
                        if (beat_q == len_q - BURST_W'(1)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StRdBurst: begin
                    if (ddr_avl_rd_req || ddr_avl_wr_req) begin
                        err_q <= 1'b1;
                    end
                    if (rd_issue) begin
                        idx_q  <= idx_q + MEM_AW'(1);
                        beat_q <= beat_q + BURST_W'(1);
                    end
                    if (out_vld) begin
                        ret_q <= ret_q + BURST_W'(1);
                        if (ret_q == len_q - BURST_W'(1)) begin
                            state_q <= StIdle;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign ddr_avl_local_init_done = init_done_q;
    assign ddr_avl_ready           = ready_q;
    assign ddr_avl_rd_data         = pipe_data_q[PIPE_D-1];
    assign ddr_avl_rd_data_vld     = out_vld;
    assign wr_beat_num             = wr_cnt_q;
    assign rd_beat_num             = rd_cnt_q;
    assign proto_err               = err_q;

endmodule

// File: tb/tb_ddr_avl_responder.sv
// Bench for ddr_avl_responder: directed bursts, expected read beats (data and cycle)
// queued at issue time and checked by an independent negedge monitor.
module tb_ddr_avl_responder;

    localparam int DATA_W  = 512;
    localparam int ADDR_W  = 26;
    localparam int BURST_W = 7;
    localparam int RL      = 4;
    localparam logic [63:0] BE_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                init_done;
    logic                ready;
    logic                rd_req;
    logic                wr_req;
    logic [ADDR_W-1:0]   address;
    logic [BURST_W-1:0]  bl_size;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_vld;
    logic [31:0]         wr_num;
    logic [31:0]         rd_num;
    logic                perr;

    int                  n_checks = 0;
    int                  n_fail   = 0;
    int                  cyc;
    exp_t                sb[$];
    logic [DATA_W-1:0]   pend[$];
    exp_t                mon_e;

    ddr_avl_responder dut (
        .sys_clk                 (clk),
        .sys_rst_n               (rst_n),
        .ddr_avl_local_init_done (init_done),
        .ddr_avl_ready           (ready),
        .ddr_avl_rd_req          (rd_req),
        .ddr_avl_wr_req          (wr_req),
        .ddr_avl_address         (address),
        .ddr_avl_bl_size         (bl_size),
        .ddr_avl_write_data      (wdata),
        .ddr_avl_be              (be),
        .ddr_avl_rd_data         (rd_data),
        .ddr_avl_rd_data_vld     (rd_vld),
        .wr_beat_num             (wr_num),
        .rd_beat_num             (rd_num),
        .proto_err               (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_vld) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_vld: got beat %0h, expected no beat", rd_data);
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", rd_data, mon_e.data);
                check("vld_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", ready, 1'b1);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input int len,
                            input logic [DATA_W-1:0] d0, input logic [63:0] bmask,
                            input int bubbles);
        wait_ready();
        for (int i = 0; i < len; i++) begin
            if (i == 1) begin
                for (int b = 0; b < bubbles; b++) begin
                    wr_req = 1'b0;
                    @(negedge clk);
                end
            end
            wr_req  = 1'b1;
            address = a;
            bl_size = BURST_W'(len);
            wdata   = d0 + DATA_W'(i);
            be      = bmask;
            @(negedge clk);
        end
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bl);
        int   n;
        int   c;
        int   lo;
        exp_t e;
        wait_ready();
        n = pend.size();
        c = cyc;
        for (int i = 0; i < n; i++) begin
            e.data = pend[i];
            e.cyc  = c + RL + i;
            sb.push_back(e);
        end
        pend.delete();
        rd_req  = 1'b1;
        address = a;
        bl_size = bl;
        @(negedge clk);
        rd_req = 1'b0;
        lo = 0;
        while (!ready && lo < 200) begin
            lo++;
            @(negedge clk);
        end
        check("ready_low_cycles", lo, RL + n - 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   first;
        int   c;
        exp_t e;
        rst_n   = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        address = '0;
        bl_size = '0;
        wdata   = '0;
        be      = '0;

        // Reset values
        #12;
        check("rst_init_done", init_done, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_vld", rd_vld, 1'b0);
        check("rst_rd_data", rd_data, '0);
        check("rst_wr_num", wr_num, 0);
        check("rst_rd_num", rd_num, 0);
        check("rst_perr", perr, 1'b0);
        #10 rst_n = 1'b1;

        // 1. Init timing, write during INIT ignored
        repeat (10) @(negedge clk);
        wr_req  = 1'b1;
        address = 26'h30;
        bl_size = 7'd1;
        wdata   = 512'h55;
        be      = BE_ALL;
        @(negedge clk);
        wr_req = 1'b0;
        first = -1;
        for (int i = 0; i < 200 && first < 0; i++) begin
            if (ready) first = cyc;
            else @(negedge clk);
        end
        check("init_ready_cycle", first, 64);
        check("init_done_with_ready", init_done, 1'b1);
        check("init_wr_ignored", wr_num, 0);
        check("init_no_perr", perr, 1'b0);

        // 2. Write then read
        do_write(26'h10, 4, 512'hA0, BE_ALL, 0);
        for (int i = 0; i < 4; i++) pend.push_back(DATA_W'(8'hA0 + i));
        do_read(26'h10, 7'd4);
        check("t2_rd_num", rd_num, 4);
        check("t2_wr_num", wr_num, 4);

        // 3. Byte enables and bubbles
        do_write(26'h20, 1, '1, BE_ALL, 0);
        do_write(26'h20, 1, '0, 64'h0F, 0);
        do_write(26'h40, 3, 512'hB0, BE_ALL, 2);
        pend.push_back({{(DATA_W-32){1'b1}}, 32'h0});
        do_read(26'h20, 7'd1);
        for (int i = 0; i < 3; i++) pend.push_back(DATA_W'(8'hB0 + i));
        do_read(26'h40, 7'd3);
        check("t3_wr_num", wr_num, 9);

        // 4. Address wrap
        do_write(26'h3FE, 3, 512'hC0, BE_ALL, 0);
        pend.push_back(512'hC2);
        do_read(26'h000, 7'd1);
        pend.push_back(512'hC0);
        pend.push_back(512'hC1);
        pend.push_back(512'hC2);
        do_read(26'h3FE, 7'd3);
        check("t4_no_perr", perr, 1'b0);
        check("t4_rd_num", rd_num, 12);

        // 5. Protocol errors: simultaneous rd+wr, then burstcount 0
        wait_ready();
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        address = 26'h50;
        bl_size = 7'd1;
        wdata   = 512'hD0;
        be      = BE_ALL;
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_perr", perr, 1'b1);
        check("t5_wr_num", wr_num, 13);
        check("t5_no_read_beats", rd_num, 12);
        pend.push_back(512'hD0);
        do_read(26'h50, 7'd1);
        pend.push_back(512'hA0);
        do_read(26'h10, 7'd0);
        check("t5_rd_num", rd_num, 14);

        // 6. Reset during second beat of an 8-beat read
        do_write(26'h100, 8, 512'hE0, BE_ALL, 0);
        wait_ready();
        c = cyc;
        for (int i = 0; i < 8; i++) begin
            e.data = DATA_W'(8'hE0 + i);
            e.cyc  = c + RL + i;
            sb.push_back(e);
        end
        rd_req  = 1'b1;
        address = 26'h100;
        bl_size = 7'd8;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("t6_second_beat_vld", rd_vld, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_vld_cleared", rd_vld, 1'b0);
        check("t6_rd_num_cleared", rd_num, 0);
        check("t6_rd_data_cleared", rd_data, '0);
        check("t6_init_done_low", init_done, 1'b0);
        check("t6_perr_cleared", perr, 1'b0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 200 && first < 0; i++) begin
            @(negedge clk);
            if (ready) first = cyc;
        end
        check("t6_reinit_cycle", first, 64);
        for (int i = 0; i < 8; i++) pend.push_back(DATA_W'(8'hE0 + i));
        do_read(26'h100, 7'd8);
        for (int i = 0; i < 4; i++) pend.push_back(DATA_W'(8'hA0 + i));
        do_read(26'h10, 7'd4);
        check("t6_rd_num", rd_num, 12);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
